// File: rtl/ntsc_clock_monitor.sv
// Frequency checker for a divided NTSC-derived clock: counts synchronised rising
// edges of sig_in over a fixed gate window and reports count, in-range and lost flags.
module ntsc_clock_monitor #(
  parameter int GATE_CYCLES = 100000,
  parameter int CNT_W       = 16,
  parameter int EXP_MIN     = 3570,
  parameter int EXP_MAX     = 3590
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             in_range,
  output logic             lost,
  output logic             busy
);

  localparam int               TMR_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(EXP_MAX);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GATE   = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  logic [1:0]       state;
  logic             s1, s2, s3;
  logic             sig_edge;
  logic [CNT_W-1:0] edge_cnt;
  logic [TMR_W-1:0] timer;

  // s1/s2 form the metastability synchroniser; s3 only delays s2 for edge detection.
  // NOTE: non-blocking assignments make s1->s2->s3 a true shift; blocking ones would collapse it into one flop.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_edge = s2 & ~s3;
  assign busy     = (state == ST_GATE);

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      edge_cnt    <= '0;
      timer       <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      lost        <= 1'b0;
    end else begin
      // NOTE: default-low here turns count_valid into a single-cycle pulse without extra state.
      count_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_GATE;
            timer    <= TMR_LOAD;
            edge_cnt <= '0;
          end
        end

        ST_GATE: begin
          if (!enable) begin
            // Abort: result outputs keep the last completed window.
            state <= ST_IDLE;
          end else begin
            if (sig_edge && (edge_cnt != CNT_MAX)) begin
              edge_cnt <= edge_cnt + CNT_W'(1);
            end
            if (timer == '0) begin
              state <= ST_REPORT;
            end else begin
              timer <= timer - TMR_W'(1);
            end
          end
        end

        ST_REPORT: begin
          count_out   <= edge_cnt;
          count_valid <= 1'b1;
          in_range    <= (edge_cnt >= CNT_LO) && (edge_cnt <= CNT_HI);
          lost        <= (edge_cnt == '0);
          if (enable) begin
            state    <= ST_GATE;
            timer    <= TMR_LOAD;
            edge_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntsc_clock_monitor.sv
// Self-checking bench for ntsc_clock_monitor: a cycle-level window model checked every
// cycle, plus directed scenarios with hand-computed counts and latencies.
module tb_ntsc_clock_monitor;

  localparam int GATE = 1000;
  localparam int CW   = 16;
  localparam int EMIN = 48;
  localparam int EMAX = 52;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock_in = 1'b0;
  logic          reset_n  = 1'b0;
  logic          sig_in   = 1'b0;
  logic          enable   = 1'b0;
  logic          enable_sat = 1'b0;
  logic [CW-1:0] count_out;
  logic          count_valid, in_range, lost, busy;
  logic [3:0]    sat_count;
  logic          sat_valid, sat_in_range, sat_lost, sat_busy;

  int checks = 0;
  int errors = 0;

  ntsc_clock_monitor #(.GATE_CYCLES(GATE), .CNT_W(CW), .EXP_MIN(EMIN), .EXP_MAX(EMAX)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .sig_in(sig_in), .enable(enable),
    .count_out(count_out), .count_valid(count_valid), .in_range(in_range),
    .lost(lost), .busy(busy)
  );

  ntsc_clock_monitor #(.GATE_CYCLES(GATE), .CNT_W(4), .EXP_MIN(0), .EXP_MAX(15)) sat_dut (
    .clock_in(clock_in), .reset_n(reset_n), .sig_in(sig_in), .enable(enable_sat),
    .count_out(sat_count), .count_valid(sat_valid), .in_range(sat_in_range),
    .lost(sat_lost), .busy(sat_busy)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sig_in generator ----------------
  // mode 0: low, 1: high, 2: periodic (lo cycles low then hi cycles high), 3: random 2..12 cycle levels
  int sig_mode = 0, sig_hi = 1, sig_lo = 1, sig_epoch = 0;
  int gen_phase = 0, gen_epoch = 0;

  task automatic set_sig(input int mode, input int hi, input int lo);
    sig_mode = mode;
    sig_hi   = hi;
    sig_lo   = lo;
    sig_epoch++;
  endtask

  always @(posedge clock_in) begin
    #2;
    if (gen_epoch != sig_epoch) begin
      gen_epoch = sig_epoch;
      gen_phase = 0;
    end
    case (sig_mode)
      0: sig_in = 1'b0;
      1: sig_in = 1'b1;
      2: begin
        sig_in    = (gen_phase >= sig_lo);
        gen_phase = (gen_phase + 1) % (sig_lo + sig_hi);
      end
      default: begin
        if (gen_phase == 0) begin
          sig_in    = ~sig_in;
          gen_phase = $urandom_range(2, 12);
        end
        gen_phase--;
      end
    endcase
  end

  // ---------------- behavioural model ----------------
  // samp holds sig_in as seen at recent clock edges; a rise seen at edge k shows up as a
  // counted edge in the cycle ending at edge k+2. Reset forgets everything seen so far.
  logic          samp [0:7];
  int            cyc = 0;
  int            gate_left = 0;
  bit            report_due = 0;
  int            m_cnt = 0;
  int            m_count = 0;
  bit            m_valid = 0, m_in_range = 0, m_lost = 0, m_busy = 0;
  bit            cmp_on = 0;

  always @(posedge clock_in) begin
    bit rise;
    rise = (cyc >= 3) && (samp[(cyc - 2) % 8] === 1'b1) && (samp[(cyc - 3) % 8] === 1'b0);
    m_valid = 0;
    if (!reset_n) begin
      samp[cyc % 8]       = 1'b0;
      samp[(cyc + 7) % 8] = 1'b0;
      samp[(cyc + 6) % 8] = 1'b0;
      gate_left  = 0;
      report_due = 0;
      m_cnt      = 0;
      m_count    = 0;
      m_in_range = 0;
      m_lost     = 0;
      cmp_on     = 1;
    end else begin
      samp[cyc % 8] = sig_in;
      if (gate_left > 0) begin
        if (!enable) begin
          gate_left = 0;
        end else begin
          if (rise && m_cnt < CMAX) m_cnt++;
          gate_left--;
          if (gate_left == 0) report_due = 1;
        end
      end else if (report_due) begin
        report_due = 0;
        m_valid    = 1;
        m_count    = m_cnt;
        m_in_range = (m_cnt >= EMIN) && (m_cnt <= EMAX);
        m_lost     = (m_cnt == 0);
        if (enable) begin
          gate_left = GATE;
          m_cnt     = 0;
        end
      end else if (enable) begin
        gate_left = GATE;
        m_cnt     = 0;
      end
    end
    m_busy = (gate_left > 0);
    cyc++;
  end

  always @(negedge clock_in) begin
    if (cmp_on) begin
      check("model_count_out",   32'(count_out),   32'(m_count));
      check("model_count_valid", 32'(count_valid), 32'(m_valid));
      check("model_in_range",    32'(in_range),    32'(m_in_range));
      check("model_lost",        32'(lost),        32'(m_lost));
      check("model_busy",        32'(busy),        32'(m_busy));
    end
  end

  // ---------------- directed helpers ----------------
  // Returns the cycle index of the count_valid pulse, cycle 0 being the cycle the call starts in.
  task automatic wait_valid(input int budget, output int n);
    n = -1;
    do begin
      @(negedge clock_in);
      n++;
    end while (count_valid !== 1'b1 && n < budget);
    check("valid_seen", 32'(count_valid), 32'd1);
  endtask

  task automatic start_window(input int mode, input int hi, input int lo);
    @(posedge clock_in); #1;
    enable = 1'b0;
    set_sig(mode, hi, lo);
    repeat (20) @(posedge clock_in);
    #1;
    enable = 1'b1;
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen;

    repeat (3) @(posedge clock_in);
    #1;
    check("reset_count_out",   32'(count_out),   32'd0);
    check("reset_count_valid", 32'(count_valid), 32'd0);
    check("reset_in_range",    32'(in_range),    32'd0);
    check("reset_lost",        32'(lost),        32'd0);
    check("reset_busy",        32'(busy),        32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clock_in);

    // Nominal: period 20 -> 50 edges per 1000-cycle window, pulse in cycle GATE+2.
    start_window(2, 10, 10);
    wait_valid(GATE + 100, n);
    check("nominal_latency", 32'(n), 32'd1002);
    check("nominal_count", 32'(count_out), 32'd50);
    check("nominal_in_range", 32'(in_range), 32'd1);
    check("nominal_lost", 32'(lost), 32'd0);

    // Too fast: period 10 -> 100 edges; back-to-back windows every GATE+1 cycles.
    start_window(2, 5, 5);
    wait_valid(GATE + 100, n);
    check("fast_count", 32'(count_out), 32'd100);
    check("fast_in_range", 32'(in_range), 32'd0);
    check("fast_lost", 32'(lost), 32'd0);
    wait_valid(GATE + 100, n);
    check("fast_period", 32'(n + 1), 32'd1001);
    check("fast_count_again", 32'(count_out), 32'd100);

    // Dead clock stuck low, then stuck high.
    start_window(0, 1, 1);
    wait_valid(GATE + 100, n);
    check("dead0_count", 32'(count_out), 32'd0);
    check("dead0_lost", 32'(lost), 32'd1);
    check("dead0_in_range", 32'(in_range), 32'd0);
    start_window(1, 1, 1);
    wait_valid(GATE + 100, n);
    check("dead1_count", 32'(count_out), 32'd0);
    check("dead1_lost", 32'(lost), 32'd1);

    // Abort: good report first, then a window dropped at cycle 500.
    start_window(2, 10, 10);
    wait_valid(GATE + 100, n);
    check("preabort_count", 32'(count_out), 32'd50);
    @(posedge clock_in); #1;
    enable = 1'b0;
    repeat (5) @(posedge clock_in);
    #1;
    enable = 1'b1;
    repeat (500) @(posedge clock_in);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    enable = 1'b0;
    @(posedge clock_in); #1;
    check("abort_busy_after", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock_in);
      if (count_valid !== 1'b0) seen = 1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    check("abort_hold_count", 32'(count_out), 32'd50);
    check("abort_hold_in_range", 32'(in_range), 32'd1);
    check("abort_hold_lost", 32'(lost), 32'd0);

    // Reset for one cycle at cycle 700 of a window; the next window reports normally.
    start_window(2, 10, 10);
    repeat (700) @(posedge clock_in);
    #1;
    reset_n = 1'b0;
    @(posedge clock_in); #1;
    reset_n = 1'b1;
    check("rst_count_out", 32'(count_out), 32'd0);
    check("rst_count_valid", 32'(count_valid), 32'd0);
    check("rst_in_range", 32'(in_range), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    wait_valid(GATE + 100, n);
    check("rst_next_latency", 32'(n), 32'd1002);
    check("rst_next_count", 32'(count_out), 32'd50);

    // Saturation on the 4-bit instance: 250 edges clamp to 15.
    start_window(2, 2, 2);
    enable = 1'b0;
    enable_sat = 1'b1;
    n = -1;
    do begin
      @(negedge clock_in);
      n++;
    end while (sat_valid !== 1'b1 && n < GATE + 100);
    check("sat_valid_seen", 32'(sat_valid), 32'd1);
    check("sat_count", 32'(sat_count), 32'd15);
    check("sat_in_range", 32'(sat_in_range), 32'd1);
    check("sat_lost", 32'(sat_lost), 32'd0);
    @(posedge clock_in); #1;
    enable_sat = 1'b0;

    // Randomized traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 15; it++) begin
      case ($urandom_range(0, 3))
        0: set_sig(2, $urandom_range(8, 12), $urandom_range(8, 12));
        1: set_sig(2, $urandom_range(2, 6), $urandom_range(2, 6));
        2: set_sig(3, 0, 0);
        default: set_sig(int'($urandom_range(0, 1)), 1, 1);
      endcase
      enable = 1'b1;
      repeat ($urandom_range(300, 2500)) @(posedge clock_in);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clock_in);
        #1;
      end
    end

    enable = 1'b0;
    repeat (5) @(posedge clock_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
